filter_sp_loader: RTL

//  Upstream controller for the filter scratchpad. Accepts a valid/ready stream of filter words.

---
 rtl/filter_sp_loader.sv | 111 +++++++++++
 1 files changed

// File: rtl/filter_sp_loader.sv
// filter_sp_loader: writes a streamed filter into the scratchpad, then replays it
// num_passes times to the MAC datapath on consumer demand.
module filter_sp_loader #(
  parameter int FILTER_WIDTH = 16,
  parameter int FILTER_ROW   = 12,
  parameter int ADDR_WIDTH   = $clog2(FILTER_ROW)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH:0]     filter_size_i,
  input  logic [7:0]              num_passes_i,
  input  logic [FILTER_WIDTH-1:0] in_data_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    rd_req_i,
  output logic [FILTER_WIDTH-1:0] rd_data_o,
  output logic                    rd_valid_o,
  output logic                    rd_last_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [FILTER_WIDTH-1:0] sp_din_o,
  output logic [ADDR_WIDTH-1:0]   sp_waddr_o,
  output logic                    sp_wen_o,
  output logic [ADDR_WIDTH-1:0]   sp_raddr_o,
  output logic                    sp_ren_o,
  output logic                    sp_chip_en_o,
  input  logic [FILTER_WIDTH-1:0] sp_dout_i
);
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_e;
  localparam logic [ADDR_WIDTH:0]   ROWS  = FILTER_ROW[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   S_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [ADDR_WIDTH:0]   size_q, size_d;
  logic [7:0]            passes_q, passes_d, pass_cnt_q, pass_cnt_d;
  logic                  rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic                  wr, rd, w_end, r_end, p_end;
  assign wr    = state_q == LOAD && in_valid_i;
  assign rd    = state_q == STREAM && rd_req_i;
  assign w_end = {1'b0, wcnt_q} == size_q - S_ONE;
  assign r_end = {1'b0, rcnt_q} == size_q - S_ONE;
  assign p_end = pass_cnt_q == passes_q - 8'd1;
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    pass_cnt_d = pass_cnt_q;
    size_d     = size_q;
    passes_d   = passes_q;
    rd_valid_d = rd;
    rd_last_d  = rd && r_end && p_end;
    case (state_q)
      IDLE: if (start_i) begin
        size_d   = filter_size_i > ROWS ? ROWS : filter_size_i;
        passes_d = num_passes_i;
        state_d  = filter_size_i == '0 ? DONE : LOAD;
      end
      LOAD: if (wr) begin
        wcnt_d = w_end ? '0 : wcnt_q + A_ONE;
        if (w_end) state_d = passes_q == '0 ? DONE : STREAM;
      end
      STREAM: if (rd) begin
        rcnt_d     = r_end ? '0 : rcnt_q + A_ONE;
        pass_cnt_d = r_end ? pass_cnt_q + 8'd1 : pass_cnt_q;
        if (r_end && p_end) state_d = DONE;
      end
      default: begin
        state_d    = IDLE;
        wcnt_d     = '0;
        rcnt_d     = '0;
        pass_cnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      pass_cnt_q <= '0;
      size_q     <= '0;
      passes_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      pass_cnt_q <= pass_cnt_d;
      size_q     <= size_d;
      passes_q   <= passes_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end
  // write data is gated so the scratchpad pins stay quiet outside a handshake
  assign in_ready_o   = state_q == LOAD;
  assign sp_wen_o     = wr;
  assign sp_din_o     = wr ? in_data_i : '0;
  assign sp_waddr_o   = wcnt_q;
  assign sp_ren_o     = rd;
  assign sp_raddr_o   = rcnt_q;
  assign busy_o       = state_q != IDLE;
  assign sp_chip_en_o = busy_o;
  assign done_o       = state_q == DONE;
  assign rd_valid_o   = rd_valid_q;
  assign rd_last_o    = rd_last_q;
  assign rd_data_o    = sp_dout_i;
endmodule
